// File: rtl/compare_sweep.sv
// Operand sweep sequencer for a W-bit greater_than comparator: walks {A,B} through
// every combination, samples F after SETTLE cycles and collects a result bitmap and count.
module compare_sweep #(
   parameter int W      = 2,
   parameter int SETTLE = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      f_in,
   output logic [W-1:0]              a_out,
   output logic [W-1:0]              b_out,
   output logic                      busy,
   output logic                      done,
   output logic [(1<<(2*W))-1:0]     result,
   output logic [2*W:0]              gt_count
);

   // state    | meaning
   // ST_IDLE  | waiting for start; outputs hold last sweep
   // ST_DRIVE | driving operands, sampling f_in every SETTLE cycles
   // ST_DONE  | one-cycle completion pulse

   localparam int IW = 2 * W;
   localparam int N  = 1 << IW;
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_DONE
   } state_t;

   state_t         state, state_nxt;
   logic [IW-1:0]  idx;
   logic [SW-1:0]  settle_cnt;
   logic           sample;
   logic           last;

   assign sample = (state == ST_DRIVE) && (settle_cnt == SW'(SETTLE - 1));
   assign last   = (idx == IW'(N - 1));
   assign a_out  = idx[IW-1:W];
   assign b_out  = idx[W-1:0];

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_DRIVE;
         end
         ST_DRIVE: begin
            busy = 1'b1;
            if (sample && last) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx        <= '0;
         settle_cnt <= '0;
         result     <= '0;
         gt_count   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  idx        <= '0;
                  settle_cnt <= '0;
                  result     <= '0;
                  gt_count   <= '0;
               end
            end
            ST_DRIVE: begin
               if (sample) begin
                  result[idx] <= f_in;
                  gt_count    <= gt_count + (IW + 1)'(f_in);
                  settle_cnt  <= '0;
                  // index is terminal at N-1 so operands hold after the sweep
                  if (!last) idx <= idx + IW'(1);
               end else begin
                  settle_cnt <= settle_cnt + SW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
